// File: rtl/axi_stream_upsizer_if.sv
// AXI4-Stream bundle shared by the upsizer and its neighbours.
// Data width is a parameter; tkeep carries one bit per byte.
interface AXI4S #(
  parameter int unsigned AXI4S_DATA_BITS = 256
) ();
  logic [AXI4S_DATA_BITS-1:0]   tdata;
  logic [AXI4S_DATA_BITS/8-1:0] tkeep;
  logic                         tlast;
  logic                         tvalid;
  logic                         tready;

  modport m (output tdata, tkeep, tlast, tvalid, input tready);
  modport s (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axi_stream_upsizer.sv
// Packs pairs of 256-bit stream beats into 512-bit beats, first beat in the low half.
// A lone trailing tlast beat is emitted with a zeroed upper half.
module axi_stream_upsizer (
  input logic clk,
  input logic rst_n,
  AXI4S.s     in,
  AXI4S.m     out
);
  localparam int unsigned IN_WIDTH  = $bits(in.tdata);
  localparam int unsigned OUT_WIDTH = $bits(out.tdata);
  localparam int unsigned IN_KEEP   = IN_WIDTH / 8;
  localparam int unsigned OUT_KEEP  = OUT_WIDTH / 8;

  if (IN_WIDTH == OUT_WIDTH) begin : g_pass
    assign out.tdata  = in.tdata;
    assign out.tkeep  = in.tkeep;
    assign out.tlast  = in.tlast;
    assign out.tvalid = in.tvalid;
    assign in.tready  = out.tready;
  end else if (IN_WIDTH == 256 && OUT_WIDTH == 512) begin : g_pack
    typedef enum logic {ST_EMPTY, ST_HALF} state_t;

    state_t                state, state_nx;
    logic                  half_valid;
    logic [IN_WIDTH-1:0]   half_data;
    logic [IN_KEEP-1:0]    half_keep;
    logic [OUT_WIDTH-1:0]  o_data, emit_data;
    logic [OUT_KEEP-1:0]   o_keep, emit_keep;
    logic                  o_last, emit_last, o_valid;
    logic                  accept, emit, load_half;

    assign half_valid = (state == ST_HALF);
    // Ready looks only at the output register, so a held half also stalls under backpressure.
    assign in.tready  = rst_n && (!o_valid || out.tready);
    assign accept     = in.tvalid && in.tready;

    always_comb begin
      state_nx  = state;
      emit      = 1'b0;
      load_half = 1'b0;
      emit_data = '0;
      emit_keep = '0;
      emit_last = 1'b0;
      if (accept) begin
        if (half_valid) begin
          emit      = 1'b1;
          emit_data = {in.tdata, half_data};
          emit_keep = {in.tkeep, half_keep};
          emit_last = in.tlast;
          state_nx  = ST_EMPTY;
        end else if (in.tlast) begin
          emit      = 1'b1;
          emit_data = {{IN_WIDTH{1'b0}}, in.tdata};
          emit_keep = {{IN_KEEP{1'b0}}, in.tkeep};
          emit_last = 1'b1;
        end else begin
          load_half = 1'b1;
          state_nx  = ST_HALF;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_EMPTY;
      else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        half_data <= '0;
        half_keep <= '0;
      end else if (load_half) begin
        half_data <= in.tdata;
        half_keep <= in.tkeep;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        o_data  <= '0;
        o_keep  <= '0;
        o_last  <= 1'b0;
        o_valid <= 1'b0;
      end else if (emit) begin
        o_data  <= emit_data;
        o_keep  <= emit_keep;
        o_last  <= emit_last;
        o_valid <= 1'b1;
      end else if (out.tready) begin
        o_valid <= 1'b0;
      end
    end

    assign out.tdata  = o_data;
    assign out.tkeep  = o_keep;
    assign out.tlast  = o_last;
    assign out.tvalid = o_valid;
  end else begin : g_bad
    $error("axi_stream_upsizer: unsupported width pair");
  end
endmodule

// File: tb/tb_axi_stream_upsizer.sv
// Bench for axi_stream_upsizer: directed vector table, reset sequences and
// randomized streams checked against a packet-level reference model.
module tb_axi_stream_upsizer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  AXI4S #(.AXI4S_DATA_BITS(256)) s_if ();
  AXI4S #(.AXI4S_DATA_BITS(512)) m_if ();

  axi_stream_upsizer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (s_if),
    .out   (m_if)
  );

  typedef struct {
    logic [255:0] d;
    logic [31:0]  k;
    logic         l;
  } beat_t;

  typedef struct {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
  } obeat_t;

  typedef struct {
    logic [255:0] d;
    logic [31:0]  k;
    logic         l;
    logic         ev;
    logic [511:0] ed;
    logic [63:0]  ek;
    logic         el;
  } vec_t;

  localparam logic [31:0] FK = 32'hFFFF_FFFF;

  int n_cmp = 0;
  int n_err = 0;

  beat_t  src_q[$];
  beat_t  pkt[$];
  obeat_t exp_q[$];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: beats of a packet pair up in arrival order; tlast closes the packet.
  function automatic void model_accept(input beat_t b);
    obeat_t o;
    pkt.push_back(b);
    if (pkt.size() == 2 || b.l) begin
      o.d = {256'b0, pkt[0].d};
      o.k = {32'b0, pkt[0].k};
      if (pkt.size() == 2) begin
        o.d[511:256] = pkt[1].d;
        o.k[63:32]   = pkt[1].k;
      end
      o.l = b.l;
      exp_q.push_back(o);
      pkt.delete();
    end
  endfunction

  function automatic vec_t mk(input logic [255:0] d, input logic [31:0] k, input logic l,
                              input logic ev, input logic [511:0] ed, input logic [63:0] ek,
                              input logic el);
    vec_t v;
    v.d = d; v.k = k; v.l = l; v.ev = ev; v.ed = ed; v.ek = ek; v.el = el;
    return v;
  endfunction

  task automatic drive_beat(input logic [255:0] d, input logic [31:0] k, input logic l);
    int  n = 0;
    bit  done = 0;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    while (!done && n < 50) begin
      @(negedge clk);
      if (s_if.tready) done = 1;
      @(posedge clk);
      #1;
      n++;
    end
    s_if.tvalid = 1'b0;
    if (!done) chk("drive_timeout", 512'(done), 512'd1);
  endtask

  // mode_rdy: 0 always ready, 1 random, 2 low during cycles 3..7. mode_vld: 0 continuous, 1 random gaps.
  task automatic run_stream(input int mode_rdy, input int mode_vld, input int budget,
                            output int n_out);
    int     cyc = 0;
    bit     stall_prev = 0;
    bit     vld;
    obeat_t held, e;
    n_out = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
      case (mode_rdy)
        0:       m_if.tready = 1'b1;
        1:       m_if.tready = 1'($urandom_range(0, 1));
        default: m_if.tready = !(cyc >= 3 && cyc <= 7);
      endcase
      vld = (src_q.size() != 0) && (mode_vld == 0 || $urandom_range(0, 3) != 0);
      s_if.tvalid = vld;
      if (vld) begin
        s_if.tdata = src_q[0].d;
        s_if.tkeep = src_q[0].k;
        s_if.tlast = src_q[0].l;
      end
      @(negedge clk);
      chk("in_tready_rule", 512'(s_if.tready), 512'(!m_if.tvalid || m_if.tready));
      if (mode_rdy == 0) chk("tput_ready", 512'(s_if.tready), 512'd1);
      if (stall_prev) begin
        chk("stall_valid", 512'(m_if.tvalid), 512'd1);
        chk("stall_data", m_if.tdata, held.d);
        chk("stall_keep_last", 512'({m_if.tkeep, m_if.tlast}), 512'({held.k, held.l}));
      end
      if (m_if.tvalid && m_if.tready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("extra_out_beat", 512'(n_out), 512'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", m_if.tdata, e.d);
          chk("out_keep", 512'(m_if.tkeep), 512'(e.k));
          chk("out_last", 512'(m_if.tlast), 512'(e.l));
        end
      end
      stall_prev = m_if.tvalid && !m_if.tready;
      held.d = m_if.tdata;
      held.k = m_if.tkeep;
      held.l = m_if.tlast;
      if (vld && s_if.tready) model_accept(src_q.pop_front());
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= budget) chk("stream_timeout", 512'(cyc), 512'(budget - 1));
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         tbl[10];
    logic [255:0] A, B, C, D, E, F, G, H, Z, W, M, J, K, L;
    int           n_out, exp_out, len;
    beat_t        b;

    A = {8{32'hA0A0_0001}}; B = {8{32'hB1B1_0002}}; C = {8{32'hC2C2_0003}};
    D = {8{32'hD3D3_0004}}; E = {8{32'hE4E4_0005}}; F = {8{32'hF5F5_0006}};
    G = {8{32'h6767_0007}}; H = {8{32'h8888_0008}}; Z = {8{32'h1234_5678}};
    W = {8{32'h9ABC_DEF0}}; M = {8{32'h5A5A_A5A5}}; J = {8{32'h0BAD_0BAD}};
    K = {8{32'h4B4B_0011}}; L = {8{32'h4C4C_0022}};

    tbl[0] = mk(A, FK, 1'b0, 1'b0, '0, '0, 1'b0);
    tbl[1] = mk(B, FK, 1'b1, 1'b1, {B, A}, {FK, FK}, 1'b1);
    tbl[2] = mk(C, 32'h0000_FFFF, 1'b1, 1'b1, {256'b0, C}, 64'h0000_0000_0000_FFFF, 1'b1);
    tbl[3] = mk(D, FK, 1'b0, 1'b0, '0, '0, 1'b0);
    tbl[4] = mk(E, FK, 1'b0, 1'b1, {E, D}, {FK, FK}, 1'b0);
    tbl[5] = mk(F, FK, 1'b1, 1'b1, {256'b0, F}, {32'b0, FK}, 1'b1);
    tbl[6] = mk(G, FK, 1'b0, 1'b0, '0, '0, 1'b0);
    tbl[7] = mk(H, FK, 1'b1, 1'b1, {H, G}, {FK, FK}, 1'b1);
    tbl[8] = mk(Z, 32'h0, 1'b0, 1'b0, '0, '0, 1'b0);
    tbl[9] = mk(W, FK, 1'b1, 1'b1, {W, Z}, {FK, 32'h0}, 1'b1);

    rst_n = 1'b0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0;
    m_if.tready = 1'b1;
    #1;
    chk("reset_tvalid", 512'(m_if.tvalid), 512'd0);
    chk("reset_in_tready", 512'(s_if.tready), 512'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tdata", m_if.tdata, '0);
    chk("reset_keep_last", 512'({m_if.tkeep, m_if.tlast}), 512'd0);
    rst_n = 1'b1;

    // Directed vectors: one beat per cycle, output checked after each accepting edge.
    for (int i = 0; i < 10; i++) begin
      s_if.tdata = tbl[i].d; s_if.tkeep = tbl[i].k; s_if.tlast = tbl[i].l;
      s_if.tvalid = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_in_tready", i), 512'(s_if.tready), 512'd1);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_tvalid", i), 512'(m_if.tvalid), 512'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_tdata", i), m_if.tdata, tbl[i].ed);
        chk($sformatf("vec%0d_tkeep", i), 512'(m_if.tkeep), 512'(tbl[i].ek));
        chk($sformatf("vec%0d_tlast", i), 512'(m_if.tlast), 512'(tbl[i].el));
      end
    end
    s_if.tvalid = 1'b0;
    @(posedge clk);
    #1;
    chk("vec_idle_tvalid", 512'(m_if.tvalid), 512'd0);

    // Reset while an output beat is stalled: tvalid must drop before any edge.
    m_if.tready = 1'b0;
    drive_beat(M, FK, 1'b1);
    chk("rst1_pending_valid", 512'(m_if.tvalid), 512'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst1_async_tvalid", 512'(m_if.tvalid), 512'd0);
    chk("rst1_in_tready", 512'(s_if.tready), 512'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_if.tready = 1'b1;

    // Reset with a held lower half: it must not reappear afterwards.
    drive_beat(J, FK, 1'b0);
    chk("rst2_half_no_out", 512'(m_if.tvalid), 512'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_async_tvalid", 512'(m_if.tvalid), 512'd0);
    chk("rst2_in_tready", 512'(s_if.tready), 512'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive_beat(K, FK, 1'b0);
    chk("rst2_k_no_out", 512'(m_if.tvalid), 512'd0);
    drive_beat(L, FK, 1'b1);
    chk("rst2_lk_valid", 512'(m_if.tvalid), 512'd1);
    chk("rst2_lk_data", m_if.tdata, {L, K});
    chk("rst2_lk_keep_last", 512'({m_if.tkeep, m_if.tlast}), 512'({FK, FK, 1'b1}));
    @(posedge clk);
    #1;
    chk("rst2_single_beat", 512'(m_if.tvalid), 512'd0);

    // Backpressure: 8 beats, downstream stalls cycles 3..7.
    for (int i = 0; i < 8; i++) begin
      b.d = rand256(); b.k = FK; b.l = (i == 7);
      src_q.push_back(b);
    end
    run_stream(2, 0, 200, n_out);
    chk("bp_out_count", 512'(n_out), 512'd4);

    // Full throughput: 100 beats, tlast every 10th.
    for (int i = 0; i < 100; i++) begin
      b.d = rand256(); b.k = FK; b.l = ((i % 10) == 9);
      src_q.push_back(b);
    end
    run_stream(0, 0, 200, n_out);
    chk("tput_out_count", 512'(n_out), 512'd50);

    // Random packets with random valid gaps and random backpressure.
    exp_out = 0;
    for (int p = 0; p < 20; p++) begin
      len = $urandom_range(1, 7);
      exp_out += (len + 1) / 2;
      for (int i = 0; i < len; i++) begin
        b.d = rand256();
        b.l = (i == len - 1);
        b.k = b.l ? 32'($urandom) : FK;
        src_q.push_back(b);
      end
    end
    run_stream(1, 1, 3000, n_out);
    chk("rand_out_count", 512'(n_out), 512'(exp_out));
    chk("rand_model_drained", 512'(pkt.size()), 512'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
